// File: rtl/adder_share_pkg.sv
// Shared constants for the adder-sharing arbiter slice.
package adder_share_pkg;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;
  localparam int DATA_W   = 32;
  localparam int CNTW_DEF = 16;
endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping mod NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win,
  output logic            any_valid
);

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    win       = '0;
    any_valid = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          win = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/thirtytwobitfa.sv
// 32-bit ripple-carry adder: sum/cout = a + b + cin.
module thirtytwobitfa
  import adder_share_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < DATA_W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[DATA_W];
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one 32-bit adder among NREQ requesters with round-robin grant
// and a single registered, ID-tagged response stage.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic [IDW-1:0]         rsp_id,
  output logic [CNTW-1:0]        ops_done
);

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    win;
  logic              any_valid;
  logic              slot_free;
  logic              accept;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic              cin_sel;
  logic [DATA_W-1:0] sum_p0;
  logic              cout_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] sum_p1;
  logic              cout_p1;
  logic [IDW-1:0]    id_p1;
  logic [CNTW-1:0]   ops_p1;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .win       (win),
    .any_valid (any_valid)
  );

  // Requests seen while rst is high must never be granted.
  assign slot_free = !vld_p1 || rsp_ready;
  assign accept    = any_valid && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    cin_sel   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        req_ready[i] = accept;
        a_sel        = req_a[i*DATA_W +: DATA_W];
        b_sel        = req_b[i*DATA_W +: DATA_W];
        cin_sel      = req_cin[i];
      end
    end
  end

  thirtytwobitfa u_add (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cin_sel),
    .sum  (sum_p0),
    .cout (cout_p0)
  );

  // p0 -> p1: response register, pointer and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      id_p1   <= '0;
      ops_p1  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (accept) begin
        vld_p1  <= 1'b1;
        sum_p1  <= sum_p0;
        cout_p1 <= cout_p0;
        id_p1   <= win;
        rr_ptr  <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      end else if (rsp_ready) begin
        vld_p1  <= 1'b0;
      end
      if (vld_p1 && rsp_ready) begin
        ops_p1 <= ops_p1 + CNTW'(1);
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_sum   = sum_p1;
  assign rsp_cout  = cout_p1;
  assign rsp_id    = id_p1;
  assign ops_done  = ops_p1;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with hand-computed expectations.
module tb_adder_share_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_sum;
  logic         rsp_cout;
  logic [1:0]   rsp_id;
  logic [15:0]  ops_done;

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(
    .NREQ (4),
    .IDW  (2),
    .CNTW (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-requester operands with precomputed 33-bit results.
  logic [31:0] op_a   [4] = '{32'h0000_0010, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'h1234_5678};
  logic [31:0] op_b   [4] = '{32'h0000_0005, 32'h0000_0001, 32'h0000_0020, 32'h1111_1111};
  logic        op_cin [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] ex_sum [4] = '{32'h0000_0016, 32'h8000_0000, 32'h0000_0011, 32'h2345_6789};
  logic        ex_cout[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst       = 1'b0;
  endtask

  task automatic load_table();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = op_a[i];
      req_b[i*32 +: 32] = op_b[i];
      req_cin[i]        = op_cin[i];
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
    end
    checks++;
    if (ops_done !== 16'd0) begin
      errors++; $display("FAIL reset_ops_done got=%0d exp=0", ops_done);
    end
    checks++;
    if (rsp_sum !== 32'd0 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_rsp_data got=%h/%b/%0d exp=0/0/0", rsp_sum, rsp_cout, rsp_id);
    end
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single_op();
    do_reset();
    req_a[31:0]  = 32'hFFFF_FFFF;
    req_b[31:0]  = 32'h0000_0001;
    req_cin[0]   = 1'b0;
    req_a[63:32] = 32'h8000_0000;
    req_b[63:32] = 32'h8000_0000;
    req_cin[1]   = 1'b1;
    rsp_ready    = 1'b1;
    req_valid    = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL single_rsp got=%b/%h/%b/%0d exp=1/00000000/1/0", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL carry_ready got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (rsp_sum !== 32'h0000_0001 || rsp_cout !== 1'b1 || rsp_id !== 2'd1 || ops_done !== 16'd1) begin
      errors++; $display("FAIL carry_rsp got=%h/%b/%0d ops=%0d exp=00000001/1/1 ops=1", rsp_sum, rsp_cout, rsp_id, ops_done);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || ops_done !== 16'd2 || rsp_sum !== 32'h0000_0001) begin
      errors++; $display("FAIL drain_idle got=%b ops=%0d sum=%h exp=0 ops=2 sum=00000001", rsp_valid, ops_done, rsp_sum);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int         w;
    do_reset();
    load_table();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      w       = k % 4;
      exp_rdy = 4'(1 << w);
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_grant step=%0d got=%b exp=%b", k, req_ready, exp_rdy);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) || rsp_sum !== ex_sum[w] || rsp_cout !== ex_cout[w]) begin
        errors++; $display("FAIL rr_rsp step=%0d got=%b/%0d/%h/%b exp=1/%0d/%h/%b",
                           k, rsp_valid, rsp_id, rsp_sum, rsp_cout, w, ex_sum[w], ex_cout[w]);
      end
    end
    req_valid = 4'b0000;
    checks++;
    if (ops_done !== 16'd7) begin
      errors++; $display("FAIL rr_ops_mid got=%0d exp=7", ops_done);
    end
    tick();
    checks++;
    if (ops_done !== 16'd8 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rr_ops_end got=%0d/%b exp=8/0", ops_done, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_a[31:0]  = 32'd5;
    req_b[31:0]  = 32'd7;
    req_cin[0]   = 1'b1;
    req_a[63:32] = 32'd100;
    req_b[63:32] = 32'd200;
    req_cin[1]   = 1'b0;
    rsp_ready    = 1'b0;
    req_valid    = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_first_ready got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_sum !== 32'd13 || rsp_id !== 2'd0) begin
        errors++; $display("FAIL bp_hold cycle=%0d got=%b/%b/%0d/%0d exp=0000/1/13/0",
                           k, req_ready, rsp_valid, rsp_sum, rsp_id);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (rsp_sum !== 32'd300 || rsp_id !== 2'd1 || ops_done !== 16'd1) begin
      errors++; $display("FAIL bp_next got=%0d/%0d ops=%0d exp=300/1 ops=1", rsp_sum, rsp_id, ops_done);
    end
    tick();
  endtask

  task automatic test_pointer_hold();
    do_reset();
    load_table();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL ptr_req2_ready got=%b exp=0100", req_ready);
    end
    tick();
    checks++;
    if (rsp_id !== 2'd2 || rsp_sum !== 32'h0000_0011) begin
      errors++; $display("FAIL ptr_req2_rsp got=%0d/%h exp=2/00000011", rsp_id, rsp_sum);
    end
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL ptr_stall_ready got=%b exp=0000", req_ready);
    end
    tick();
    tick();
    checks++;
    if (rsp_id !== 2'd2 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL ptr_stall_hold got=%0d/%b exp=2/1", rsp_id, rsp_valid);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL ptr_after_stall got=%b exp=1000", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (rsp_id !== 2'd3 || rsp_sum !== 32'h2345_6789) begin
      errors++; $display("FAIL ptr_req3_rsp got=%0d/%h exp=3/23456789", rsp_id, rsp_sum);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    load_table();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    checks++;
    if (ops_done !== 16'd1) begin
      errors++; $display("FAIL mid_pre_ops got=%0d exp=1", ops_done);
    end
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      errors++; $display("FAIL mid_pending got=%b/%0d exp=1/1", rsp_valid, rsp_id);
    end
    req_valid = 4'b1111;
    rst       = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || ops_done !== 16'd0 || rsp_sum !== 32'd0) begin
      errors++; $display("FAIL mid_rst_state got=%b/%0d/%h exp=0/0/00000000", rsp_valid, ops_done, rsp_sum);
    end
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_restart_ready got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h0000_0016) begin
      errors++; $display("FAIL mid_restart_rsp got=%b/%0d/%h exp=1/0/00000016", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_pointer_hold();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
